// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard controller state encoding, the zero
// register index and the hazard cause enum exposed for debug.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Listed in no particular order; priority is resolved in hazard_ctrl.
  typedef enum logic [2:0] {
    HZ_NONE    = 3'd0,
    HZ_MEM     = 3'd1,
    HZ_BRANCH  = 3'd2,
    HZ_LOADUSE = 3'd3,
    HZ_JUMP    = 3'd4
  } hazard_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush controls for the 5-stage core,
// data-memory wait tracking with a sticky timeout, and performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_counters,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout,
  output state_e           dbg_state,
  output hazard_e          dbg_hazard
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_e          state, state_nxt;
  hazard_e         hazard;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_wait_now, rs_hit, rt_hit, load_use, flush_inc;

  assign mem_wait_now = mem_req && !mem_ready;
  assign rs_hit       = id_use_rs && (id_rs == ex_wreg);
  assign rt_hit       = id_use_rt && (id_rt == ex_wreg);
  assign load_use     = ex_memread && (ex_wreg != REG_ZERO) && (rs_hit || rt_hit);

  // Memory freeze overrides everything; a jump behind a load-use simply
  // retries next cycle once the load has left EX.
  always_comb begin
    hazard = HZ_NONE;
    if (reset)                hazard = HZ_NONE;
    else if (mem_wait_now)    hazard = HZ_MEM;
    else if (ex_branch_taken) hazard = HZ_BRANCH;
    else if (load_use)        hazard = HZ_LOADUSE;
    else if (id_jump)         hazard = HZ_JUMP;
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    case (hazard)
      HZ_MEM: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end
      HZ_BRANCH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      HZ_LOADUSE: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      HZ_JUMP: if_id_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_wait_now) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready)    state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // The wait keeps going after the timeout; only the flag records it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!mem_wait_now)          wait_cnt <= '0;
      else if (wait_cnt != WC_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (clr_counters)                                mem_timeout <= 1'b0;
      else if (mem_wait_now && (wait_cnt >= WC_LAST))  mem_timeout <= 1'b1;
    end
  end

  assign flush_inc = (hazard == HZ_BRANCH) || (hazard == HZ_JUMP);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stall),
    .clr   (clr_counters),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .clr   (clr_counters),
    .count (flush_events)
  );

  assign dbg_state  = state;
  assign dbg_hazard = hazard;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected control vectors are queued as
// stimulus is applied and compared at the following negative clock edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_wreg;
  logic id_use_rs, id_use_rt, id_jump, ex_memread, ex_branch_taken;
  logic mem_req, mem_ready, clr_counters;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  state_e  dbg_state;
  hazard_e dbg_hazard;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .clr_counters(clr_counters),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .mem_timeout(mem_timeout), .dbg_state(dbg_state), .dbg_hazard(dbg_hazard)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  int m_stall, m_flush, m_wait;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  function automatic logic [6:0] ctl_model();
    bit lu;
    if (reset) return 7'b0000000;
    if (mem_req && !mem_ready) return 7'b1101011;
    if (ex_branch_taken) return 7'b0010100;
    lu = ex_memread && (ex_wreg != 5'd0) &&
         ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
    if (lu) return 7'b1100100;
    if (id_jump) return 7'b0010000;
    return 7'b0000000;
  endfunction

  function automatic logic [6:0] ctl_obs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, mem_wb_flush};
  endfunction

  // Inputs are already set; check controls mid-cycle, then advance the model.
  task automatic cycle(input string tag);
    logic [6:0] e;
    e = ctl_model();
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, 32'(ctl_obs()), 32'(exp_q.pop_front()));
    if (!reset) begin
      if (clr_counters) begin
        m_stall = 0; m_flush = 0; m_timeout = 0;
      end else begin
        if (e[6] && m_stall < CMAX) m_stall++;
        if (e[4] && m_flush < CMAX) m_flush++;
      end
      if (mem_req && !mem_ready) begin
        if (m_wait < MEM_TIMEOUT) m_wait++;
        if (m_wait == MEM_TIMEOUT && !clr_counters) m_timeout = 1;
      end else begin
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_stall"}, 32'(stall_cycles), 32'(m_stall));
    check({tag, "_flush"}, 32'(flush_events), 32'(m_flush));
    check({tag, "_tmo"}, 32'(mem_timeout), 32'(m_timeout));
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_jump = 1'b0; ex_memread = 1'b0; ex_wreg = 5'd0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; clr_counters = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_memread = 1'b1; ex_wreg = r; id_rs = r; id_use_rs = 1'b1;
  endtask

  initial begin
    m_stall = 0; m_flush = 0; m_wait = 0; m_timeout = 0;
    idle_inputs();
    reset = 1'b1;
    // controls must stay low under reset even with a pending memory wait
    mem_req = 1'b1;
    #2;
    cycle("reset_ctl");
    check_cnt("reset");
    check("reset_state", 32'(dbg_state), 32'(RUN));
    idle_inputs();
    reset = 1'b0;
    cycle("idle");
    check_cnt("idle");

    // load-use on rs: one bubble
    set_load_use(5'd8);
    check("lu_hz", 32'(dbg_hazard), 32'(HZ_LOADUSE));
    cycle("lu");
    ex_memread = 1'b0;
    cycle("lu_after");
    check_cnt("lu");

    // no stall for $zero destination or unused source
    set_load_use(5'd0);
    cycle("lu_zero");
    set_load_use(5'd8);
    id_use_rs = 1'b0;
    cycle("lu_unused");
    id_rt = 5'd8; id_use_rt = 1'b1;
    cycle("lu_rt");
    check_cnt("lu_misc");
    idle_inputs();

    // branch beats load-use
    set_load_use(5'd9);
    ex_branch_taken = 1'b1;
    cycle("br_lu");
    check_cnt("br_lu");
    ex_branch_taken = 1'b0;

    // jump waits behind the load-use bubble
    id_jump = 1'b1;
    cycle("jmp_lu");
    ex_memread = 1'b0;
    cycle("jmp_after");
    check_cnt("jmp");
    idle_inputs();

    // three wait cycles with a taken branch during the wait
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken = (i == 1);
      cycle($sformatf("wait%0d", i));
      check("wait_state", 32'(dbg_state), 32'(MEM_WAIT));
    end
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    cycle("wait_done");
    check("wait_run", 32'(dbg_state), 32'(RUN));
    check_cnt("wait");
    idle_inputs();

    // six wait cycles cross the timeout
    mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle($sformatf("tmo%0d", i));
      check_cnt($sformatf("tmo%0d", i));
    end
    mem_ready = 1'b1;
    cycle("tmo_done");
    idle_inputs();
    cycle("tmo_idle");
    check_cnt("tmo_sticky");

    // clear wins over a concurrent stall increment
    set_load_use(5'd12);
    clr_counters = 1'b1;
    cycle("clr");
    check_cnt("clr");
    clr_counters = 1'b0;

    // stall counter saturates
    for (int i = 0; i < CMAX + 5; i++) begin
      id_rs = 5'($urandom_range(1, 31));
      ex_wreg = id_rs;
      cycle("sat");
    end
    check_cnt("sat");
    idle_inputs();

    // reset in the middle of a wait drops everything at once
    mem_req = 1'b1;
    cycle("rst_wait0");
    cycle("rst_wait1");
    reset = 1'b1;
    #1;
    check("rst_async_ctl", 32'(ctl_obs()), 32'd0);
    check("rst_async_state", 32'(dbg_state), 32'(RUN));
    m_stall = 0; m_flush = 0; m_wait = 0; m_timeout = 0;
    check_cnt("rst_async");
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
